// File: rtl/sorted_display_driver.sv
// Latches four sorted hex values on a rising start_display and scans them onto a
// 4-digit common-anode 7-segment display, pulsing frame_done at the end of each frame.
module sorted_display_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_display,
  input  logic [3:0] sorted_num0,
  input  logic [3:0] sorted_num1,
  input  logic [3:0] sorted_num2,
  input  logic [3:0] sorted_num3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nxt;
  logic             start_d;
  logic             capture;
  logic [3:0][3:0]  lat, lat_nxt;
  logic [1:0]       digit, digit_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             frame_nxt;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 7'b1000000;
      4'h1:    hex_to_seg = 7'b1111001;
      4'h2:    hex_to_seg = 7'b0100100;
      4'h3:    hex_to_seg = 7'b0110000;
      4'h4:    hex_to_seg = 7'b0011001;
      4'h5:    hex_to_seg = 7'b0010010;
      4'h6:    hex_to_seg = 7'b0000010;
      4'h7:    hex_to_seg = 7'b1111000;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0010000;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b0000011;
      4'hC:    hex_to_seg = 7'b1000110;
      4'hD:    hex_to_seg = 7'b0100001;
      4'hE:    hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  // Outputs are derived from next-state values so they settle on the same edge as the state.
  always_comb begin
    capture   = start_display & ~start_d;
    state_nxt = state;
    lat_nxt   = lat;
    digit_nxt = digit;
    cnt_nxt   = cnt;
    frame_nxt = 1'b0;
    if (capture) begin
      lat_nxt   = {sorted_num3, sorted_num2, sorted_num1, sorted_num0};
      state_nxt = SCAN;
      digit_nxt = 2'd0;
      cnt_nxt   = '0;
    end else if (state == SCAN) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt   = '0;
        digit_nxt = digit + 2'd1;
        frame_nxt = (digit == 2'd3);
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
    an_nxt  = 4'b1111;
    seg_nxt = 7'b1111111;
    if (state_nxt == SCAN) begin
      an_nxt  = ~(4'b0001 << digit_nxt);
      seg_nxt = hex_to_seg(lat_nxt[digit_nxt]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_d    <= 1'b0;
      lat        <= '0;
      digit      <= 2'd0;
      cnt        <= '0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_d    <= start_display;
      lat        <= lat_nxt;
      digit      <= digit_nxt;
      cnt        <= cnt_nxt;
      an         <= an_nxt;
      seg        <= seg_nxt;
      frame_done <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_sorted_display_driver.sv
// Bench for sorted_display_driver: directed scenarios plus random traffic, checked against
// a time-since-capture model of the display scan.
module tb_sorted_display_driver;

  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_display;
  logic [3:0] sorted_num0, sorted_num1, sorted_num2, sorted_num3;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: display is a pure function of the captured values and cycles since capture.
  bit         m_active;
  bit         m_prev;
  int         m_t;
  logic [3:0] m_vals [4];

  sorted_display_driver #(.REFRESH_DIV(R)) dut (
    .clk(clk), .rst_n(rst_n), .start_display(start_display),
    .sorted_num0(sorted_num0), .sorted_num1(sorted_num1),
    .sorted_num2(sorted_num2), .sorted_num3(sorted_num3),
    .an(an), .seg(seg), .frame_done(frame_done));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_active = 0; m_prev = 0; m_t = 0;
    end else begin
      if (start_display && !m_prev) begin
        m_vals[0] = sorted_num0; m_vals[1] = sorted_num1;
        m_vals[2] = sorted_num2; m_vals[3] = sorted_num3;
        m_active = 1; m_t = 0;
      end else if (m_active) begin
        m_t++;
      end
      m_prev = start_display;
    end
    #1;
  endtask

  function automatic int m_digit();
    return (m_t / R) % 4;
  endfunction

  function automatic logic [11:0] model_out();
    logic [3:0] a;
    logic       fd;
    if (!m_active) return {4'b1111, 7'b1111111, 1'b0};
    a  = 4'b0001 << m_digit();
    fd = (m_t > 0) && (m_t % (4 * R) == 0);
    return {~a, seg_tab[m_vals[m_digit()]], fd};
  endfunction

  task automatic set_nums(input logic [3:0] a, b, c, d);
    sorted_num0 = a; sorted_num1 = b; sorted_num2 = c; sorted_num3 = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_display = 1'b0; set_nums(4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({an, seg, frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
        failures++;
        $display("FAIL reset_blank cyc=%0d got an=%b seg=%b fd=%b want an=1111 seg=1111111 fd=0",
                 i, an, seg, frame_done);
      end
    end
  endtask

  task automatic test_capture_scan();
    logic [11:0] exp;
    set_nums(4'h1, 4'h3, 4'h9, 4'hC);
    start_display = 1'b1;
    tick();
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1111001) begin
      failures++;
      $display("FAIL capture_first got an=%b seg=%b want an=1110 seg=1111001", an, seg);
    end
    for (int i = 1; i <= 4 * R; i++) begin
      if (i == 2) set_nums(4'hF, 4'hF, 4'hF, 4'hF);
      tick();
      exp = model_out();
      checks++;
      if ({an, seg, frame_done} !== exp || $countones(~an) > 1) begin
        failures++;
        $display("FAIL capture_scan cyc=%0d got=%b_%b_%b want=%b", i, an, seg, frame_done, exp);
      end
    end
    checks++;
    if (frame_done !== 1'b1 || an !== 4'b1110 || seg !== 7'b1111001) begin
      failures++;
      $display("FAIL frame_pulse got fd=%b an=%b seg=%b want fd=1 an=1110 seg=1111001",
               frame_done, an, seg);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL frame_one_cycle got fd=%b want 0", frame_done);
    end
  endtask

  task automatic test_input_change();
    logic [11:0] exp;
    set_nums(4'hF, 4'hF, 4'hF, 4'hF);
    for (int i = 0; i < 4 * R; i++) begin
      tick();
      exp = model_out();
      checks++;
      if ({an, seg, frame_done} !== exp || seg === 7'b0001110) begin
        failures++;
        $display("FAIL input_hold cyc=%0d got=%b_%b_%b want=%b", i, an, seg, frame_done, exp);
      end
    end
  endtask

  task automatic wait_digit(input int target, input string tag);
    int n = 0;
    while (!(m_active && m_digit() == target && m_t % R == 0) && n < 100) begin
      tick(); n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL %s_timeout got digit=%0d want digit=%0d", tag, m_digit(), target);
    end
  endtask

  task automatic test_recapture();
    logic [11:0] exp;
    wait_digit(2, "recap");
    start_display = 1'b0;
    tick();
    set_nums(4'h0, 4'h0, 4'h5, 4'hA);
    start_display = 1'b1;
    tick();
    checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL recapture_first got an=%b seg=%b fd=%b want an=1110 seg=1000000 fd=0",
               an, seg, frame_done);
    end
    for (int i = 1; i <= 3 * R; i++) begin
      tick();
      exp = model_out();
      checks++;
      if ({an, seg, frame_done} !== exp) begin
        failures++;
        $display("FAIL recapture_scan cyc=%0d got=%b_%b_%b want=%b", i, an, seg, frame_done, exp);
      end
    end
    checks++;
    if (an !== 4'b0111 || seg !== 7'b0001000) begin
      failures++;
      $display("FAIL recapture_digit3 got an=%b seg=%b want an=0111 seg=0001000", an, seg);
    end
  endtask

  task automatic test_wrap_capture();
    // Re-arm the edge so a capture lands exactly on the digit-3 wrap edge.
    wait_digit(3, "wrap");
    for (int i = 0; i < R - 2; i++) tick();
    start_display = 1'b0;
    set_nums(4'h7, 4'h2, 4'h4, 4'h6);
    tick();
    start_display = 1'b1;
    tick();
    checks++;
    if (frame_done !== 1'b0 || an !== 4'b1110 || seg !== 7'b1111000) begin
      failures++;
      $display("FAIL wrap_capture got fd=%b an=%b seg=%b want fd=0 an=1110 seg=1111000",
               frame_done, an, seg);
    end
  endtask

  task automatic test_reset_mid();
    wait_digit(1, "rstmid");
    rst_n = 1'b0;
    tick();
    checks++;
    if ({an, seg, frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got an=%b seg=%b fd=%b want an=1111 seg=1111111 fd=0",
               an, seg, frame_done);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({an, seg, frame_done} !== model_out() || an !== 4'b1110) begin
      failures++;
      $display("FAIL reset_recapture got=%b_%b_%b want=%b", an, seg, frame_done, model_out());
    end
  endtask

  task automatic test_decode_sweep();
    for (int v = 0; v < 16; v++) begin
      start_display = 1'b0;
      tick();
      set_nums(4'(v), 4'($urandom), 4'($urandom), 4'($urandom));
      start_display = 1'b1;
      tick();
      checks++;
      if (seg !== seg_tab[v] || an !== 4'b1110 || {an, seg, frame_done} !== model_out()) begin
        failures++;
        $display("FAIL decode_%0d got an=%b seg=%b want an=1110 seg=%b", v, an, seg, seg_tab[v]);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] exp;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 9) == 0) start_display = ~start_display;
      set_nums(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      tick();
      exp = model_out();
      checks++;
      if ({an, seg, frame_done} !== exp || $countones(~an) > 1) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b_%b_%b want=%b", i, an, seg, frame_done, exp);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    m_active = 0; m_prev = 0; m_t = 0;
    for (int i = 0; i < 4; i++) m_vals[i] = 4'h0;
    test_reset();
    test_capture_scan();
    test_input_change();
    test_recapture();
    test_wrap_capture();
    test_reset_mid();
    test_decode_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
